// File: rtl/rv32i_core.sv
// rv32i_core: 3-stage (IF/ID/EX) in-order RV32I integer core, no data-memory port.
// Instructions come from a combinational ROM addressed by inst_addr_o.
// Writeback happens at the edge that ends EX; a one-entry bypass feeds ID.
// Optional feature macro: ILLEGAL_HALT_EN -- when defined, an unknown opcode
// reaching EX freezes the core until reset; otherwise it retires as a NOP.

// Register file: 32 x 32, two combinational read ports, one write port.
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);
    logic [31:0] regs [0:31];

    // Clear all registers on reset, otherwise commit EX results (x0 never written).
    // NOTE: every entry is reset, so x0 and the probed array start defined; this keeps the file in flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != 5'd0)) begin
            regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'd0 : regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'd0 : regs[i_rs2_addr];
endmodule

module rv32i_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_addr_o
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Fetch and pipeline registers
    logic [31:0] r_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc;
    logic [6:0]  r_idex_opcode;
    logic [4:0]  r_idex_rd;
    logic [2:0]  r_idex_funct3;
    logic        r_idex_alt;
    logic [31:0] r_idex_pc;
    logic [31:0] r_idex_rs1;
    logic [31:0] r_idex_rs2;
    logic [31:0] r_idex_imm;

    // ID stage signals
    logic [6:0]  w_id_opcode;
    logic [4:0]  w_id_rs1_addr;
    logic [4:0]  w_id_rs2_addr;
    logic [31:0] w_id_imm;
    logic [31:0] w_rf_rs1;
    logic [31:0] w_rf_rs2;
    logic [31:0] w_id_rs1_val;
    logic [31:0] w_id_rs2_val;

    // EX stage signals
    logic [31:0] w_alu_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu_out;
    logic        w_br_cond;
    logic [31:0] w_ex_result;
    logic        w_ex_wr;
    logic        w_ex_wr_en;
    logic        w_ex_taken;
    logic [31:0] w_ex_target;
    logic        w_halt;

    assign inst_addr_o = r_pc;

    // ---------------- ID ----------------
    assign w_id_opcode   = r_ifid_inst[6:0];
    assign w_id_rs1_addr = r_ifid_inst[19:15];
    assign w_id_rs2_addr = r_ifid_inst[24:20];

    // Immediate generation, format chosen by opcode; I-type is the fallback.
    // NOTE: every path assigns w_id_imm (the default arm included), so no latch is inferred.
    always_comb begin
        case (w_id_opcode)
            OPC_LUI, OPC_AUIPC:
                w_id_imm = {r_ifid_inst[31:12], 12'd0};
            OPC_JAL:
                w_id_imm = {{11{r_ifid_inst[31]}}, r_ifid_inst[31], r_ifid_inst[19:12],
                            r_ifid_inst[20], r_ifid_inst[30:21], 1'b0};
            OPC_BRANCH:
                w_id_imm = {{19{r_ifid_inst[31]}}, r_ifid_inst[31], r_ifid_inst[7],
                            r_ifid_inst[30:25], r_ifid_inst[11:8], 1'b0};
            OPC_STORE:
                w_id_imm = {{20{r_ifid_inst[31]}}, r_ifid_inst[31:25], r_ifid_inst[11:7]};
            default:
                w_id_imm = {{20{r_ifid_inst[31]}}, r_ifid_inst[31:20]};
        endcase
    end

    rv32i_regfile u_regs (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (w_id_rs1_addr),
        .o_rs1_data (w_rf_rs1),
        .i_rs2_addr (w_id_rs2_addr),
        .o_rs2_data (w_rf_rs2),
        .i_wr_en    (w_ex_wr_en),
        .i_wr_addr  (r_idex_rd),
        .i_wr_data  (w_ex_result)
    );

    // The EX result is written at the same edge ID samples, so forward it.
    assign w_id_rs1_val = (w_ex_wr_en && (r_idex_rd == w_id_rs1_addr)) ? w_ex_result : w_rf_rs1;
    assign w_id_rs2_val = (w_ex_wr_en && (r_idex_rd == w_id_rs2_addr)) ? w_ex_result : w_rf_rs2;

    // ---------------- EX ----------------
    assign w_alu_b = (r_idex_opcode == OPC_OP) ? r_idex_rs2 : r_idex_imm;
    assign w_shamt = w_alu_b[4:0];

    // Shared ALU for OP and OP-IMM; SUB only exists in the register form.
    always_comb begin
        case (r_idex_funct3)
            3'b000:  w_alu_out = ((r_idex_opcode == OPC_OP) && r_idex_alt)
                                 ? (r_idex_rs1 - w_alu_b) : (r_idex_rs1 + w_alu_b);
            3'b001:  w_alu_out = r_idex_rs1 << w_shamt;
            3'b010:  w_alu_out = {31'd0, $signed(r_idex_rs1) < $signed(w_alu_b)};
            3'b011:  w_alu_out = {31'd0, r_idex_rs1 < w_alu_b};
            3'b100:  w_alu_out = r_idex_rs1 ^ w_alu_b;
            3'b101:  w_alu_out = r_idex_alt ? 32'($signed(r_idex_rs1) >>> w_shamt)
                                            : (r_idex_rs1 >> w_shamt);
            3'b110:  w_alu_out = r_idex_rs1 | w_alu_b;
            default: w_alu_out = r_idex_rs1 & w_alu_b;
        endcase
    end

    // Branch condition from funct3; reserved encodings never branch.
    always_comb begin
        case (r_idex_funct3)
            3'b000:  w_br_cond = (r_idex_rs1 == r_idex_rs2);
            3'b001:  w_br_cond = (r_idex_rs1 != r_idex_rs2);
            3'b100:  w_br_cond = ($signed(r_idex_rs1) <  $signed(r_idex_rs2));
            3'b101:  w_br_cond = ($signed(r_idex_rs1) >= $signed(r_idex_rs2));
            3'b110:  w_br_cond = (r_idex_rs1 <  r_idex_rs2);
            3'b111:  w_br_cond = (r_idex_rs1 >= r_idex_rs2);
            default: w_br_cond = 1'b0;
        endcase
    end

    // Per-opcode result, writeback request and redirect.
    always_comb begin
        w_ex_result = 32'd0;
        w_ex_wr     = 1'b0;
        w_ex_taken  = 1'b0;
        w_ex_target = r_idex_pc + r_idex_imm;
        case (r_idex_opcode)
            OPC_LUI: begin
                w_ex_result = r_idex_imm;
                w_ex_wr     = 1'b1;
            end
            OPC_AUIPC: begin
                w_ex_result = r_idex_pc + r_idex_imm;
                w_ex_wr     = 1'b1;
            end
            OPC_JAL: begin
                w_ex_result = r_idex_pc + 32'd4;
                w_ex_wr     = 1'b1;
                w_ex_taken  = 1'b1;
            end
            OPC_JALR: begin
                w_ex_result = r_idex_pc + 32'd4;
                w_ex_wr     = 1'b1;
                w_ex_taken  = 1'b1;
                w_ex_target = (r_idex_rs1 + r_idex_imm) & ~32'd1;
            end
            OPC_BRANCH: begin
                w_ex_taken = w_br_cond;
            end
            OPC_OPIMM, OPC_OP: begin
                w_ex_result = w_alu_out;
                w_ex_wr     = 1'b1;
            end
            default: begin
                // Loads, stores, FENCE, SYSTEM and unknown opcodes retire silently.
            end
        endcase
    end

    assign w_ex_wr_en = w_ex_wr && (r_idex_rd != 5'd0);

`ifdef ILLEGAL_HALT_EN
    logic w_ex_illegal;
    logic r_halted;

    // Any opcode outside the RV32I base map counts as illegal.
    always_comb begin
        case (r_idex_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM:
                w_ex_illegal = 1'b0;
            default:
                w_ex_illegal = 1'b1;
        endcase
    end

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_ex_illegal) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halt = r_halted || w_ex_illegal;
`else
    assign w_halt = 1'b0;
`endif

    // PC and pipeline advance: reset, then halt, then redirect flush, then normal flow.
    // NOTE: non-blocking assignments here let every stage sample the previous cycle's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_ifid_inst   <= NOP_INST;
            r_ifid_pc     <= 32'd0;
            r_idex_opcode <= NOP_INST[6:0];
            r_idex_rd     <= NOP_INST[11:7];
            r_idex_funct3 <= NOP_INST[14:12];
            r_idex_alt    <= NOP_INST[30];
            r_idex_pc     <= 32'd0;
            r_idex_rs1    <= 32'd0;
            r_idex_rs2    <= 32'd0;
            r_idex_imm    <= 32'd0;
        end else if (w_halt || w_ex_taken) begin
            if (w_ex_taken && !w_halt) begin
                r_pc <= w_ex_target;
            end
            r_ifid_inst   <= NOP_INST;
            r_ifid_pc     <= 32'd0;
            r_idex_opcode <= NOP_INST[6:0];
            r_idex_rd     <= NOP_INST[11:7];
            r_idex_funct3 <= NOP_INST[14:12];
            r_idex_alt    <= NOP_INST[30];
            r_idex_pc     <= 32'd0;
            r_idex_rs1    <= 32'd0;
            r_idex_rs2    <= 32'd0;
            r_idex_imm    <= 32'd0;
        end else begin
            r_pc          <= r_pc + 32'd4;
            r_ifid_inst   <= inst_i;
            r_ifid_pc     <= r_pc;
            r_idex_opcode <= w_id_opcode;
            r_idex_rd     <= r_ifid_inst[11:7];
            r_idex_funct3 <= r_ifid_inst[14:12];
            r_idex_alt    <= r_ifid_inst[30];
            r_idex_pc     <= r_ifid_pc;
            r_idex_rs1    <= w_id_rs1_val;
            r_idex_rs2    <= w_id_rs2_val;
            r_idex_imm    <= w_id_imm;
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Self-checking bench for rv32i_core: directed programs in a behavioural ROM,
// a table of expected register values, and fetch-address sequence checks.
module tb_rv32i_core;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ILLEGAL   = 32'hFFFF_FFFF;
    localparam int          TRACE_LEN = 160;
    localparam int          N_VEC     = 30;

    localparam int OPIMM = 7'h13;
    localparam int OP    = 7'h33;
    localparam int LUI   = 7'h37;
    localparam int AUIPC = 7'h17;
    localparam int JALR  = 7'h67;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_o;
    logic [31:0] rom   [0:4095];
    logic [31:0] trace [0:TRACE_LEN-1];
    vec_t        vecs  [0:N_VEC-1];
    int          checks   = 0;
    int          failures = 0;

    rv32i_core dut (
        .clk         (clk),
        .rst         (rst),
        .inst_i      (inst_i),
        .inst_addr_o (inst_addr_o)
    );

    assign inst_i = rom[inst_addr_o[13:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] i_type(input int op, input int f3, input int rd,
                                           input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] r_type(input int f7, input int f3, input int rd,
                                           input int rs1, input int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(OP)};
    endfunction

    function automatic logic [31:0] b_type(input int f3, input int rs1, input int rs2,
                                           input int off);
        logic [12:1] o;
        o = 12'(off >>> 1);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] jal_w(input int rd, input int off);
        logic [20:1] j;
        j = 20'(off >>> 1);
        return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] u_type(input int op, input int rd, input int imm20);
        return {20'(imm20), 5'(rd), 7'(op)};
    endfunction

    // ---------------- bench utilities ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [4:0] idx);
        return dut.u_regs.regs[idx];
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (10) tick();
    endtask

    task automatic run_trace(input int n);
        trace[0] = inst_addr_o;
        for (int k = 1; k < n; k++) begin
            tick();
            trace[k] = inst_addr_o;
        end
    endtask

    // Find the first fetch of 'start' and compare the three fetches after it.
    task automatic check_seq(input string name, input logic [31:0] start,
                             input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        int k;
        k = -1;
        for (int i = 0; i < TRACE_LEN - 3; i++) begin
            if (k < 0 && trace[i] == start) k = i;
        end
        if (k < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: fetch address 0x%08h never seen", name, start);
        end else begin
            check({name, "+1"}, trace[k+1], e1);
            check({name, "+2"}, trace[k+2], e2);
            check({name, "+3"}, trace[k+3], e3);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = NOP;
    endtask

    task automatic load_main();
        clear_rom();
        rom[0]  = i_type(OPIMM, 0, 10, 0, 2);         // 00 addi x10,x0,2
        rom[1]  = i_type(OPIMM, 0, 11, 11, 1);        // 04 addi x11,x11,1
        rom[2]  = r_type(0, 0, 12, 11, 10);           // 08 add  x12,x11,x10
        rom[3]  = r_type(32, 0, 13, 12, 10);          // 0C sub  x13,x12,x10
        rom[4]  = jal_w(1, 8);                        // 10 jal  x1,+8
        rom[5]  = i_type(OPIMM, 0, 14, 0, 99);        // 14 skipped
        rom[6]  = i_type(OPIMM, 0, 15, 0, 7);         // 18 addi x15,x0,7
        rom[7]  = i_type(OPIMM, 0, 16, 0, -1);        // 1C addi x16,x0,-1
        rom[8]  = i_type(OPIMM, 0, 17, 0, 1);         // 20 addi x17,x0,1
        rom[9]  = r_type(0, 2, 18, 16, 17);           // 24 slt  x18,x16,x17
        rom[10] = r_type(0, 3, 19, 16, 17);           // 28 sltu x19,x16,x17
        rom[11] = i_type(OPIMM, 5, 20, 16, 'h404);    // 2C srai x20,x16,4
        rom[12] = i_type(OPIMM, 5, 21, 16, 4);        // 30 srli x21,x16,4
        rom[13] = i_type(OPIMM, 0, 0, 0, 5);          // 34 addi x0,x0,5
        rom[14] = r_type(0, 0, 22, 0, 0);             // 38 add  x22,x0,x0
        rom[15] = b_type(0, 10, 10, 12);              // 3C beq  x10,x10,+12
        rom[16] = i_type(OPIMM, 0, 23, 0, 11);        // 40 squashed
        rom[17] = i_type(OPIMM, 0, 23, 0, 12);        // 44 squashed
        rom[18] = b_type(1, 10, 10, 8);               // 48 bne  x10,x10,+8 (not taken)
        rom[19] = i_type(OPIMM, 0, 24, 0, 21);        // 4C addi x24,x0,21
        rom[20] = i_type(OPIMM, 0, 25, 24, 1);        // 50 addi x25,x24,1
        rom[21] = u_type(LUI, 5, 'h12345);            // 54 lui  x5,0x12345
        rom[22] = u_type(AUIPC, 6, 1);                // 58 auipc x6,1
`ifdef ILLEGAL_HALT_EN
        rom[23] = NOP;                                // 5C halt variant tested separately
`else
        rom[23] = ILLEGAL;                            // 5C unknown opcode, runs as NOP
`endif
        rom[24] = i_type(OPIMM, 0, 7, 0, 'h71);       // 60 addi x7,x0,0x71
        rom[25] = i_type(JALR, 0, 8, 7, 0);           // 64 jalr x8,0(x7) -> 0x70
        rom[26] = i_type(OPIMM, 0, 9, 0, 33);         // 68 squashed
        rom[27] = i_type(OPIMM, 0, 9, 0, 34);         // 6C squashed
        rom[28] = b_type(4, 16, 17, 8);               // 70 blt  x16,x17,+8 (taken)
        rom[29] = i_type(OPIMM, 0, 9, 0, 35);         // 74 squashed
        rom[30] = b_type(7, 16, 17, 8);               // 78 bgeu x16,x17,+8 (taken)
        rom[31] = i_type(OPIMM, 0, 9, 0, 36);         // 7C squashed
        rom[32] = r_type(0, 1, 28, 17, 10);           // 80 sll  x28,x17,x10
        rom[33] = i_type(OPIMM, 4, 29, 16, 'hF0);     // 84 xori x29,x16,0xF0
        rom[34] = r_type(0, 7, 30, 29, 21);           // 88 and  x30,x29,x21
        rom[35] = r_type(0, 6, 31, 10, 28);           // 8C or   x31,x10,x28
        rom[36] = u_type(LUI, 3, 'h80000);            // 90 lui  x3,0x80000
        rom[37] = r_type(32, 5, 4, 3, 17);            // 94 sra  x4,x3,x17
        rom[38] = r_type(0, 5, 2, 3, 17);             // 98 srl  x2,x3,x17
        rom[39] = jal_w(0, 0);                        // 9C jal  x0,0 (spin)
    endtask

    task automatic load_illegal_prog();
        clear_rom();
        rom[0] = i_type(OPIMM, 0, 1, 0, 5);           // 00 addi x1,x0,5
        rom[1] = ILLEGAL;                             // 04 unknown opcode
        rom[2] = i_type(OPIMM, 0, 2, 0, 6);           // 08 addi x2,x0,6
        rom[3] = i_type(OPIMM, 0, 3, 0, 7);           // 0C addi x3,x0,7
        rom[4] = jal_w(0, 0);                         // 10 jal  x0,0
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{5'd0,  32'h0000_0000};
        vecs[1]  = '{5'd1,  32'h0000_0014};
        vecs[2]  = '{5'd2,  32'h4000_0000};
        vecs[3]  = '{5'd3,  32'h8000_0000};
        vecs[4]  = '{5'd4,  32'hC000_0000};
        vecs[5]  = '{5'd5,  32'h1234_5000};
        vecs[6]  = '{5'd6,  32'h0000_1058};
        vecs[7]  = '{5'd7,  32'h0000_0071};
        vecs[8]  = '{5'd8,  32'h0000_0068};
        vecs[9]  = '{5'd9,  32'h0000_0000};
        vecs[10] = '{5'd10, 32'h0000_0002};
        vecs[11] = '{5'd11, 32'h0000_0001};
        vecs[12] = '{5'd12, 32'h0000_0003};
        vecs[13] = '{5'd13, 32'h0000_0001};
        vecs[14] = '{5'd14, 32'h0000_0000};
        vecs[15] = '{5'd15, 32'h0000_0007};
        vecs[16] = '{5'd16, 32'hFFFF_FFFF};
        vecs[17] = '{5'd17, 32'h0000_0001};
        vecs[18] = '{5'd18, 32'h0000_0001};
        vecs[19] = '{5'd19, 32'h0000_0000};
        vecs[20] = '{5'd20, 32'hFFFF_FFFF};
        vecs[21] = '{5'd21, 32'h0FFF_FFFF};
        vecs[22] = '{5'd22, 32'h0000_0000};
        vecs[23] = '{5'd23, 32'h0000_0000};
        vecs[24] = '{5'd24, 32'h0000_0015};
        vecs[25] = '{5'd25, 32'h0000_0016};
        vecs[26] = '{5'd28, 32'h0000_0004};
        vecs[27] = '{5'd29, 32'hFFFF_FF0F};
        vecs[28] = '{5'd30, 32'h0FFF_FF0F};
        vecs[29] = '{5'd31, 32'h0000_0006};

        // Phase 1: reset, then the main program.
        load_main();
        apply_reset();
        check("reset_pc", inst_addr_o, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), reg_val(5'(i)), 32'h0);

        rst = 1'b0;
        run_trace(TRACE_LEN);
        check("fetch_1", trace[1], 32'h4);
        check("fetch_2", trace[2], 32'h8);

        for (int v = 0; v < N_VEC; v++) begin
            check($sformatf("x%0d", vecs[v].idx), reg_val(vecs[v].idx), vecs[v].exp);
        end

        check_seq("jal",      32'h10, 32'h14, 32'h18, 32'h18);
        check_seq("beq_take", 32'h3C, 32'h40, 32'h44, 32'h48);
        check_seq("bne_fall", 32'h48, 32'h4C, 32'h50, 32'h54);
        check_seq("jalr",     32'h64, 32'h68, 32'h6C, 32'h70);

        // Phase 2: reset with a dirty register file, then an unknown opcode.
        load_illegal_prog();
        apply_reset();
        check("reset2_pc", inst_addr_o, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("reset2_x%0d", i), reg_val(5'(i)), 32'h0);

        rst = 1'b0;
        run_trace(30);
        check("ill_x1", reg_val(5'd1), 32'd5);
`ifdef ILLEGAL_HALT_EN
        check("halt_x2", reg_val(5'd2), 32'd0);
        check("halt_x3", reg_val(5'd3), 32'd0);
        for (int k = 3; k < 30; k += 6) check($sformatf("halt_pc_%0d", k), trace[k], 32'h0C);
        check("halt_pc_end", trace[29], 32'h0C);
`else
        check("ill_x2", reg_val(5'd2), 32'd6);
        check("ill_x3", reg_val(5'd3), 32'd7);
        check("ill_pc_3", trace[3], 32'h0C);
        check("ill_pc_4", trace[4], 32'h10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
